// File: rtl/spi_tx_arbiter_if.sv
// Requester and SPI-core handshake bundle shared by spi_tx_arbiter and its environment.
interface spi_tx_arbiter_if #(
    parameter int unsigned CH_NUM = 4
);
    localparam int unsigned GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic [CH_NUM-1:0]   In_req;
    logic [8*CH_NUM-1:0] In_req_data;
    logic [CH_NUM-1:0]   Out_ack;
    logic [CH_NUM-1:0]   Out_done;
    logic [CH_NUM-1:0]   Out_err;
    logic [GW-1:0]       Out_grant;
    logic                Out_busy;
    logic                Out_tx_req;
    logic [7:0]          Out_tx_data;
    logic                In_tx_busy;

    // Arbiter side
    modport master (
        input  In_req, In_req_data, In_tx_busy,
        output Out_ack, Out_done, Out_err, Out_grant, Out_busy, Out_tx_req, Out_tx_data
    );

    // Requesters plus SPI core side
    modport slave (
        output In_req, In_req_data, In_tx_busy,
        input  Out_ack, Out_done, Out_err, Out_grant, Out_busy, Out_tx_req, Out_tx_data
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI byte transmitter between CH_NUM level-request channels.
// All outputs are registered; ack/done/err are single-cycle one-hot pulses.
module spi_tx_arbiter #(
    parameter int unsigned CH_NUM        = 4,
    parameter int unsigned START_TIMEOUT = 16
) (
    input logic                In_clk,
    input logic                In_rst_n,
    spi_tx_arbiter_if.master   bus
);
    localparam int unsigned GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned CW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_nx;
    logic [GW-1:0]     rr_q, rr_nx;
    logic [GW-1:0]     grant_q, grant_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;
    logic [CH_NUM-1:0] ack_q, ack_nx;
    logic [CH_NUM-1:0] done_q, done_nx;
    logic [CH_NUM-1:0] err_q, err_nx;
    logic              tx_req_q, tx_req_nx;
    logic [7:0]        tx_data_q, tx_data_nx;
    logic              busy_q, busy_nx;

    logic [GW-1:0]     idx;
    logic [GW-1:0]     pick;
    logic [7:0]        pick_data;
    logic              any_req;
    logic [GW-1:0]     next_ptr;

    // Scan from the highest offset down so the set bit nearest rr_q is the last one kept.
    always_comb begin
        idx       = '0;
        pick      = '0;
        pick_data = '0;
        any_req   = 1'b0;
        for (int k = int'(CH_NUM) - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_q) + k) % int'(CH_NUM));
            if (bus.In_req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
        for (int c = 0; c < int'(CH_NUM); c++) begin
            if (pick == GW'(c)) begin
                pick_data = bus.In_req_data[8*c +: 8];
            end
        end
    end

    assign next_ptr = (grant_q == GW'(CH_NUM - 1)) ? '0 : grant_q + GW'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_nx   = state_q;
        rr_nx      = rr_q;
        grant_nx   = grant_q;
        cnt_nx     = cnt_q;
        tx_req_nx  = 1'b0;
        tx_data_nx = tx_data_q;
        ack_nx     = '0;
        done_nx    = '0;
        err_nx     = '0;
        unique case (state_q)
            IDLE: begin
                if (!bus.In_tx_busy && any_req) begin
                    state_nx   = ISSUE;
                    grant_nx   = pick;
                    tx_data_nx = pick_data;
                    tx_req_nx  = 1'b1;
                    ack_nx     = CH_NUM'(1) << pick;
                end
            end
            ISSUE: begin
                state_nx = WAIT_START;
                cnt_nx   = '0;
            end
            WAIT_START: begin
                if (bus.In_tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT)) begin
                    state_nx = IDLE;
                    err_nx   = CH_NUM'(1) << grant_q;
                    rr_nx    = next_ptr;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.In_tx_busy) begin
                    state_nx = IDLE;
                    done_nx  = CH_NUM'(1) << grant_q;
                    rr_nx    = next_ptr;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            rr_q      <= rr_nx;
            grant_q   <= grant_nx;
            cnt_q     <= cnt_nx;
            tx_req_q  <= tx_req_nx;
            tx_data_q <= tx_data_nx;
            ack_q     <= ack_nx;
            done_q    <= done_nx;
            err_q     <= err_nx;
            busy_q    <= busy_nx;
        end
    end

    assign bus.Out_ack     = ack_q;
    assign bus.Out_done    = done_q;
    assign bus.Out_err     = err_q;
    assign bus.Out_grant   = grant_q;
    assign bus.Out_busy    = busy_q;
    assign bus.Out_tx_req  = tx_req_q;
    assign bus.Out_tx_data = tx_data_q;
endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin arbiter that shares one `spi_master_tx_mode0` byte transmitter between `CH_NUM` requesters. Each requester uses a level-request / pulse-acknowledge handshake. The arbiter picks one requester, forwards its byte through the core's `In_tx_req`/`In_tx_data`/`Out_tx_busy` interface, and reports completion per channel. It sits between application-side byte producers and the SPI master core, in the `In_clk` domain.

## Interface
- `CH_NUM`, default 4: number of requesters; legal range 2..8.
- `START_TIMEOUT`, default 16: clock cycles to wait for core busy to rise after issue before aborting.
- `In_clk`, input, 1: system clock, rising edge.
- `In_rst_n`, input, 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `In_req`, input, CH_NUM: per-channel request level; bit i is held high until `Out_ack[i]`.
- `In_req_data`, input, 8*CH_NUM: per-channel byte; channel i occupies bits [8i+7:8i]; held stable while `In_req[i]` is high.
- `Out_ack`, output, CH_NUM: one-cycle pulse; the channel's byte has been handed to the core.
- `Out_done`, output, CH_NUM: one-cycle pulse; the channel's byte has finished shifting out.
- `Out_err`, output, CH_NUM: one-cycle pulse; start timeout fired for the channel.
- `Out_grant`, output, $clog2(CH_NUM): index of the current or last granted channel.
- `Out_busy`, output, 1: high in every state except IDLE.
- `Out_tx_req`, output, 1: drives core `In_tx_req`.
- `Out_tx_data`, output, 8: drives core `In_tx_data`.
- `In_tx_busy`, input, 1: from core `Out_tx_busy`.

## Operation
- States:
  - IDLE: wait for a request.
  - ISSUE: request is presented to the core.
  - WAIT_START: wait for the core to accept.
  - WAIT_DONE: wait for the byte to finish.
- IDLE → ISSUE when `In_tx_busy` = 0 and `In_req` ≠ 0:
  - Grant g = first set bit of `In_req`, searching from `rr_ptr` upward with wrap-around.
  - Register `Out_tx_data` = byte g, `Out_grant` = g, `Out_tx_req` = 1.
  - Pulse `Out_ack[g]` on the following cycle.
- While `In_tx_busy` = 1 in IDLE (core busy from elsewhere or still finishing), no grant is made.
- ISSUE → WAIT_START after exactly one cycle; `Out_tx_req` returns to 0. The core samples req and data in the ISSUE cycle.
- WAIT_START:
  - → WAIT_DONE when `In_tx_busy` = 1.
  - Otherwise a timeout counter increments each cycle. When the count reaches `START_TIMEOUT`: pulse `Out_err[g]`, set `rr_ptr` = (g+1) mod CH_NUM, go to IDLE. No `Out_done` is issued.
- WAIT_DONE → IDLE when `In_tx_busy` = 0: pulse `Out_done[g]` and set `rr_ptr` = (g+1) mod CH_NUM.
- `In_req` is sampled only in IDLE. Requests raised during a transfer wait for IDLE.
- A requester that keeps `In_req` high after its ack is treated as a new request at the next IDLE. Fairness is preserved because `rr_ptr` has already advanced past it.
- `Out_tx_data` holds its value after the transfer until the next grant.
- Reset, asynchronous and allowed mid-transfer:
  - State = IDLE, `rr_ptr` = 0, timeout counter = 0.
  - `Out_tx_req` = 0, `Out_tx_data` = 0, `Out_grant` = 0.
  - `Out_ack`, `Out_done`, `Out_err` = 0; `Out_busy` = 0.
  - No done or err pulse is generated for an aborted transfer.

## Timing
- Cycle T (IDLE, request seen, core idle): grant is decided.
- T+1: `Out_tx_req` = 1, `Out_ack[g]` = 1, `Out_busy` = 1, state ISSUE.
- T+2: `Out_tx_req` = 0, state WAIT_START. The core raises busy at T+2 (one cycle after accept), so WAIT_DONE is entered at T+3.
- `Out_done[g]` asserts in the cycle after `In_tx_busy` is first seen low in WAIT_DONE. The state is IDLE in that same cycle.
- Earliest next grant decision: the cycle in which `Out_done` is high. The next `Out_tx_req` follows one cycle later.
- Minimum gap between core requests: 2 cycles after busy falls.
- Timeout: `Out_err` asserts `START_TIMEOUT`+1 cycles after `Out_tx_req` falls, in the same cycle state returns to IDLE.
- At most one of `Out_ack`/`Out_done`/`Out_err` bits is high in any cycle, and each is a single-cycle pulse.

## Test plan
- Single channel: `In_req` = 4'b0100, data2 = 8'hA5, core model busy for 100 cycles → `Out_ack[2]` at T+1, `Out_tx_req` pulse of 1 cycle with `Out_tx_data` = 8'hA5, `Out_done[2]` once, `Out_grant` = 2.
- Simultaneous requests: `In_req` = 4'b1111 held (re-raised after each ack), bytes 8'h10/11/12/13 → grant order 0,1,2,3,0; mosi bytes in the same order; no channel served twice in a row.
- Wrap-around: `rr_ptr` = 3 (after serving ch2), `In_req` = 4'b0011 → ch0 granted before ch1.
- Core busy at request: hold `In_tx_busy` = 1 for 50 cycles with `In_req` = 4'b0001 → no `Out_tx_req` until busy falls, then grant within 1 cycle.
- Timeout: core model never raises busy → `Out_err[g]` after 17 cycles, no `Out_done`, state IDLE, `rr_ptr` advanced.
- Reset mid-transfer: assert `In_rst_n` = 0 during WAIT_DONE → all outputs 0 immediately; after release with `In_req` = 4'b0010 → ch1 granted normally.
